// File: rtl/dds_ctrl_pkg.sv
// Shared widths and FSM encoding for the DDS tone sweep sequencer.
package dds_ctrl_pkg;

   localparam int DEF_INCR_W  = 32;
   localparam int DEF_DIV_W   = 16;
   localparam int DEF_DWELL_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/step_divider.sv
// Programmable strobe divider: one-cycle strobe every (div+1) enabled cycles.
// Dropping en clears the count and kills any strobe due at that edge.
module step_divider #(
   parameter int DIV_W = 16
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             step
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             step_q, step_d;

   // Next count / strobe: wrap and fire when the count reaches div.
   always_comb begin
      cnt_d  = '0;
      step_d = 1'b0;
      if (en) begin
         if (cnt_q == div) begin
            cnt_d  = '0;
            step_d = 1'b1;
         end else begin
            cnt_d  = cnt_q + DIV_W'(1);
         end
      end
   end

   // Count and strobe registers.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         cnt_q  <= '0;
         step_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         step_q <= step_d;
      end
   end

   assign step = step_q;

endmodule

// File: rtl/tone_sweep_ctrl.sv
// Linear phase-increment sweep sequencer for the DDS sine generator.
// Plays start..stop in delta steps, holding each point for (dwell+1) strobes.
module tone_sweep_ctrl
   import dds_ctrl_pkg::*;
#(
   parameter int INCR_W  = DEF_INCR_W,
   parameter int DIV_W   = DEF_DIV_W,
   parameter int DWELL_W = DEF_DWELL_W
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               start_in,
   input  logic               abort_in,
   input  logic [DIV_W-1:0]   div_in,
   input  logic [DWELL_W-1:0] dwell_in,
   input  logic [INCR_W-1:0]  start_incr_in,
   input  logic [INCR_W-1:0]  stop_incr_in,
   input  logic [INCR_W-1:0]  delta_incr_in,
   output logic               step_out,
   output logic [INCR_W-1:0]  phase_incr_out,
   output logic               busy_out,
   output logic               done_out
);

   state_t               state_q, state_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic [DWELL_W-1:0]   dwell_q, dwell_d;
   logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
   logic [INCR_W-1:0]    stop_q, stop_d;
   logic [INCR_W-1:0]    delta_q, delta_d;
   logic [INCR_W-1:0]    incr_q, incr_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 div_en;
   logic                 step;
   logic [INCR_W:0]      next_sum;

   // One extra bit so a wrap past the top of the increment range shows as carry.
   assign next_sum = {1'b0, incr_q} + {1'b0, delta_q};

   // Next state, config latching, dwell counting and point advance.
   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      dwell_d     = dwell_q;
      stop_d      = stop_q;
      delta_d     = delta_q;
      incr_d      = incr_q;
      dwell_cnt_d = dwell_cnt_q;
      case (state_q)
         IDLE: begin
            if (start_in && !abort_in) begin
               state_d     = RUN;
               div_d       = div_in;
               dwell_d     = dwell_in;
               stop_d      = stop_incr_in;
               delta_d     = delta_incr_in;
               incr_d      = start_incr_in;
               dwell_cnt_d = '0;
            end
         end
         RUN: begin
            if (abort_in) begin
               state_d = IDLE;
            end else if (step) begin
               if (dwell_cnt_q < dwell_q) begin
                  dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
               end else if ((delta_q == '0) || next_sum[INCR_W] ||
                            (next_sum[INCR_W-1:0] > stop_q)) begin
                  state_d = DONE;
               end else begin
                  incr_d      = next_sum[INCR_W-1:0];
                  dwell_cnt_d = '0;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
      // Divider runs only while staying in RUN, so leaving RUN suppresses a coincident strobe
      // and entering RUN starts the count from zero.
      div_en = (state_q == RUN) && (state_d == RUN);
   end

   // State, config copies, counters and registered outputs.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q     <= IDLE;
         div_q       <= '0;
         dwell_q     <= '0;
         stop_q      <= '0;
         delta_q     <= '0;
         incr_q      <= '0;
         dwell_cnt_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         dwell_q     <= dwell_d;
         stop_q      <= stop_d;
         delta_q     <= delta_d;
         incr_q      <= incr_d;
         dwell_cnt_q <= dwell_cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   step_divider #(.DIV_W(DIV_W)) u_div (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .en     (div_en),
      .div    (div_q),
      .step   (step)
   );

   assign step_out       = step;
   assign phase_incr_out = incr_q;
   assign busy_out       = busy_q;
   assign done_out       = done_q;

endmodule

// File: tb/tb_tone_sweep_ctrl.sv
// Directed bench for tone_sweep_ctrl with hand-computed strobe timing and increments.
module tb_tone_sweep_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        start_in = 1'b0;
   logic        abort_in = 1'b0;
   logic [15:0] div_in = '0;
   logic [15:0] dwell_in = '0;
   logic [31:0] start_incr_in = '0;
   logic [31:0] stop_incr_in = '0;
   logic [31:0] delta_incr_in = '0;
   logic        step_out;
   logic [31:0] phase_incr_out;
   logic        busy_out;
   logic        done_out;

   int n_chk  = 0;
   int n_pass = 0;

   int          s_cyc[$];
   logic [31:0] s_inc[$];
   int          exp_c[$];
   logic [31:0] exp_i[$];
   int          done_cyc;

   always #5 clk_in = ~clk_in;

   tone_sweep_ctrl dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .start_in       (start_in),
      .abort_in       (abort_in),
      .div_in         (div_in),
      .dwell_in       (dwell_in),
      .start_incr_in  (start_incr_in),
      .stop_incr_in   (stop_incr_in),
      .delta_incr_in  (delta_incr_in),
      .step_out       (step_out),
      .phase_incr_out (phase_incr_out),
      .busy_out       (busy_out),
      .done_out       (done_out)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // Launch a sweep; returns 1ns after edge E0.
   task automatic start_sweep(input logic [15:0] dv, input logic [15:0] dw,
                              input logic [31:0] st, input logic [31:0] sp,
                              input logic [31:0] dl);
      div_in = dv; dwell_in = dw;
      start_incr_in = st; stop_incr_in = sp; delta_incr_in = dl;
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
   endtask

   // Record strobes (cycle index after E0, increment) until done_out or budget runs out.
   task automatic collect(input int budget);
      s_cyc.delete();
      s_inc.delete();
      done_cyc = -1;
      for (int k = 1; k <= budget; k++) begin
         tick();
         if (step_out) begin
            s_cyc.push_back(k);
            s_inc.push_back(phase_incr_out);
         end
         if (done_out) begin
            done_cyc = k;
            break;
         end
      end
   endtask

   task automatic check_sweep(input string tag, input int exp_done, input logic [31:0] exp_last);
      chk({tag, "_nstrobe"}, 64'(s_cyc.size()), 64'(exp_c.size()));
      for (int i = 0; i < exp_c.size() && i < s_cyc.size(); i++) begin
         chk($sformatf("%s_cyc%0d", tag, i), 64'(s_cyc[i]), 64'(exp_c[i]));
         chk($sformatf("%s_inc%0d", tag, i), 64'(s_inc[i]), 64'(exp_i[i]));
      end
      chk({tag, "_done_cyc"}, 64'(done_cyc), 64'(exp_done));
      chk({tag, "_busy_at_done"}, 64'(busy_out), 64'(0));
      chk({tag, "_step_at_done"}, 64'(step_out), 64'(0));
      chk({tag, "_hold"}, 64'(phase_incr_out), 64'(exp_last));
      tick();
      chk({tag, "_done_1cyc"}, 64'(done_out), 64'(0));
   endtask

   initial begin
      // Power-on reset
      #12;
      chk("rst_step", 64'(step_out), 64'(0));
      chk("rst_incr", 64'(phase_incr_out), 64'(0));
      chk("rst_busy", 64'(busy_out), 64'(0));
      chk("rst_done", 64'(done_out), 64'(0));
      rst_in = 1'b1;
      tick();

      // Basic sweep: 3 points x 2 strobes, 3 cycles apart
      start_sweep(16'd2, 16'd1, 32'd100, 32'd300, 32'd100);
      chk("sw_busy", 64'(busy_out), 64'(1));
      chk("sw_incr0", 64'(phase_incr_out), 64'(100));
      collect(40);
      exp_c = '{3, 6, 9, 12, 15, 18};
      exp_i = '{100, 100, 200, 200, 300, 300};
      check_sweep("sweep", 19, 32'd300);

      // Boundary: next point overshoots stop, div=0 back-to-back strobes
      start_sweep(16'd0, 16'd0, 32'd100, 32'd250, 32'd100);
      collect(20);
      exp_c = '{1, 2};
      exp_i = '{100, 200};
      check_sweep("bound", 3, 32'd200);

      // Back-to-back: start right after the done cycle with new config
      start_sweep(16'd4, 16'd0, 32'd7, 32'd7, 32'd1);
      chk("b2b_busy", 64'(busy_out), 64'(1));
      collect(20);
      exp_c = '{5};
      exp_i = '{7};
      check_sweep("b2b", 6, 32'd7);

      // Carry out of the adder must end the sweep, never wrap
      start_sweep(16'd1, 16'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200);
      collect(20);
      exp_c = '{2};
      exp_i = '{32'hFFFF_FF00};
      check_sweep("carry", 3, 32'hFFFF_FF00);

      // Zero delta: single point played for dwell+1 strobes
      start_sweep(16'd0, 16'd2, 32'd500, 32'd1000, 32'd0);
      collect(20);
      exp_c = '{1, 2, 3};
      exp_i = '{500, 500, 500};
      check_sweep("delta0", 4, 32'd500);

      // stop < start: start point only
      start_sweep(16'd0, 16'd1, 32'd700, 32'd100, 32'd10);
      collect(20);
      exp_c = '{1, 2};
      exp_i = '{700, 700};
      check_sweep("stoplt", 3, 32'd700);

      // Abort on a strobe edge, with a stray start pulse during RUN
      start_sweep(16'd3, 16'd0, 32'd40, 32'd1000, 32'd5);
      tick();                                   // k=1
      start_in = 1'b1; start_incr_in = 32'd999; div_in = 16'd0;
      tick();                                   // k=2
      start_in = 1'b0;
      chk("ab_ign_incr", 64'(phase_incr_out), 64'(40));
      chk("ab_ign_step", 64'(step_out), 64'(0));
      tick();                                   // k=3
      chk("ab_step3", 64'(step_out), 64'(0));
      tick();                                   // k=4
      chk("ab_step4", 64'(step_out), 64'(1));
      chk("ab_inc4", 64'(phase_incr_out), 64'(40));
      tick();                                   // k=5
      chk("ab_inc5", 64'(phase_incr_out), 64'(45));
      tick();                                   // k=6
      tick();                                   // k=7, div_cnt reaches div during next cycle
      abort_in = 1'b1;
      tick();                                   // k=8
      abort_in = 1'b0;
      chk("ab_step", 64'(step_out), 64'(0));
      chk("ab_busy", 64'(busy_out), 64'(0));
      chk("ab_done", 64'(done_out), 64'(0));
      chk("ab_hold", 64'(phase_incr_out), 64'(45));
      tick();
      chk("ab_done2", 64'(done_out), 64'(0));
      chk("ab_busy2", 64'(busy_out), 64'(0));

      // start and abort together in IDLE: stay idle
      div_in = 16'd0;
      start_in = 1'b1; abort_in = 1'b1;
      tick();
      start_in = 1'b0; abort_in = 1'b0;
      chk("sa_busy", 64'(busy_out), 64'(0));
      tick();
      chk("sa_step", 64'(step_out), 64'(0));
      chk("sa_incr", 64'(phase_incr_out), 64'(45));

      // Async reset mid-sweep
      start_sweep(16'd1, 16'd3, 32'd55, 32'd500, 32'd5);
      tick();
      tick();
      chk("mr_busy_pre", 64'(busy_out), 64'(1));
      chk("mr_step_pre", 64'(step_out), 64'(1));
      #2 rst_in = 1'b0;
      #1;
      chk("mr_step", 64'(step_out), 64'(0));
      chk("mr_incr", 64'(phase_incr_out), 64'(0));
      chk("mr_busy", 64'(busy_out), 64'(0));
      chk("mr_done", 64'(done_out), 64'(0));
      #2 rst_in = 1'b1;
      tick();
      chk("mr_idle_busy", 64'(busy_out), 64'(0));
      tick();
      tick();
      chk("mr_idle_step", 64'(step_out), 64'(0));
      chk("mr_idle_done", 64'(done_out), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
